// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states and
// the hex-to-segment encoding (active-high, bit order g f e d c b a).
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg7_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_OFF;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern (g..a).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_decode(hex);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous display
// updates through a one-entry valid/ready pending buffer.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned REFRESH_TICKS = 50000,
    parameter int unsigned BLANK_TICKS   = 500,
    parameter bit          ACTIVE_LOW    = 1'b1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_value,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic [DIGITS-1:0]     wr_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic                  frame_tick
);

    localparam int unsigned MAX_TICKS = (REFRESH_TICKS > BLANK_TICKS) ? REFRESH_TICKS : BLANK_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
    localparam int unsigned IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    // With no blank phase the FSM lives entirely in SHOW, including after reset.
    localparam seg7_state_e START_STATE = (BLANK_TICKS > 0) ? BLANK : SHOW;

    localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_INV = {7{ACTIVE_LOW}};

    seg7_state_e        state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               boundary;

    logic [4*DIGITS-1:0] shadow_value, pend_value;
    logic [DIGITS-1:0]   shadow_dp, pend_dp;
    logic [DIGITS-1:0]   shadow_en, pend_en;
    logic                pend_full;
    logic                accept;

    logic [3:0]          nibble;
    logic [6:0]          dec_seg;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;
    logic                dp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START_STATE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt + CW'(1);
        boundary = 1'b0;
        unique case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_n   = '0;
                    state_n = START_STATE;
                    if (idx == IDX_LAST) begin
                        idx_n    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign wr_ready = ~pend_full;
    assign accept   = wr_valid & ~pend_full;

    // A write on the boundary cycle can only land in an empty buffer, so it
    // never races the shadow load; it waits for the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full    <= 1'b0;
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_en      <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
        end else begin
            if (boundary && pend_full) begin
                shadow_value <= pend_value;
                shadow_dp    <= pend_dp;
                shadow_en    <= pend_en;
            end
            if (accept) begin
                pend_value <= wr_value;
                pend_dp    <= wr_dp;
                pend_en    <= wr_en;
                pend_full  <= 1'b1;
            end else if (boundary) begin
                pend_full <= 1'b0;
            end
        end
    end

    always_comb begin
        nibble = shadow_value[{idx, 2'b00} +: 4];
    end

    hex_to_seg7 u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        an_d  = '0;
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        if (state == SHOW && shadow_en[idx]) begin
            an_d[idx] = 1'b1;
            seg_d     = dec_seg;
            dp_d      = shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_INV;
            seg        <= SEG_INV;
            dp_out     <= ACTIVE_LOW;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_d ^ AN_INV;
            seg        <= seg_d ^ SEG_INV;
            dp_out     <= dp_d ^ ACTIVE_LOW;
            frame_tick <= boundary;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Drives a multiplexed, common-anode seven-segment display bank from the board clock. This is the output-side counterpart to the key debouncer: the debouncer cleans physical inputs, and this block times and drives physical outputs. Core logic posts display updates through a valid/ready handshake. Updates are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_TICKS, 50000, clk cycles each digit is lit per frame (>=1)
BLANK_TICKS, 500, all-off guard cycles before each digit, for anti-ghosting (0 = no blank phase)
ACTIVE_LOW, 1, 1 = an/seg/dp pins are active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  update request
wr_ready  out  1  block can accept an update
wr_value  in  4*DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
wr_dp  in  DIGITS  decimal point per digit
wr_en  in  DIGITS  digit enable; a disabled digit stays dark during its slot
an  out  DIGITS  digit (anode) selects
seg  out  7  segments, bit order g f e d c b a (bit6..bit0)
dp_out  out  1  decimal point segment
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (async assert, sync release): state = BLANK, digit index = 0, tick counter = 0; shadow value/dp/en = 0, so the display is dark; pending buffer empty; wr_ready = 1; frame_tick = 0; all pins inactive (ACTIVE_LOW=1: an = all 1s, seg = 7'h7F, dp_out = 1).
- FSM states:
  - BLANK: lasts BLANK_TICKS cycles, all pins inactive, then goes to SHOW.
  - SHOW: lasts REFRESH_TICKS cycles, then goes to BLANK with index+1. After index DIGITS-1, the index wraps to 0.
  - If BLANK_TICKS = 0, BLANK is skipped: SHOW goes directly to SHOW of the next digit.
- SHOW outputs:
  - an asserts only bit [index], and only if shadow_en[index] = 1; otherwise all digits are inactive.
  - seg = hex decode of shadow nibble[index]; dp_out = shadow_dp[index].
  - Polarity inversion per ACTIVE_LOW applies to all pins.
- Outputs are registered: pins reflect the FSM state with exactly 1 cycle latency.
- Frame length = DIGITS*(BLANK_TICKS+REFRESH_TICKS) cycles. frame_tick is registered and aligned with the last lit cycle on the pins of digit DIGITS-1.
- Handshake:
  - A transfer occurs when wr_valid && wr_ready. The payload is captured into a one-entry pending buffer and wr_ready drops the next cycle.
  - At the frame boundary (last SHOW cycle of digit DIGITS-1), a pending payload moves to the shadow registers and the buffer empties. wr_ready returns to 1 on the following cycle.
  - The first frame using the new data starts at digit 0.
  - wr_value/wr_dp/wr_en are ignored while wr_ready = 0. wr_valid may be held high indefinitely without side effects.
- Simultaneous events: a write accepted on the boundary cycle (buffer empty) goes into the pending buffer. It does not reach the shadow registers until the next boundary.
- Counter width is $clog2(max(REFRESH_TICKS, BLANK_TICKS)+1). Index width is $clog2(DIGITS), minimum 1.
- Hex decode (active-high, g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Reset mid-operation: pins go inactive immediately (asynchronously) and the pending update is discarded.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry segment encoding constants, or a decode function;
  - the SEG_OFF constant;
  - the FSM state typedef {BLANK, SHOW}.
- One natural combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-high out). Instantiate it once, fed by the index-muxed nibble.

Test Plan:
Bench config for all scenarios: DIGITS=4, REFRESH_TICKS=4, BLANK_TICKS=2, ACTIVE_LOW=1.
1. Reset, then idle 30 cycles -> an=4'hF, seg=7'h7F, dp_out=1, wr_ready=1 throughout; frame_tick pulses every 24 cycles.
2. Write value=16'h12AF, en=4'hF, dp=4'b0010 -> wr_ready=0 until the next boundary. The following frame shows:
   - digit0: an=4'b1110, seg=7'h0E (F) for 4 cycles, preceded by 2 all-off cycles;
   - digit1: an=4'b1101, seg=7'h08 (A), dp_out=0;
   - digit2: seg=7'h24 (2);
   - digit3: seg=7'h79 (1).
3. Hold wr_valid=1 with a second payload 16'h3333 mid-frame -> it is not accepted until one cycle after the boundary, and no frame ever mixes 12AF and 3333 nibbles.
4. Write with en=4'b0101 -> an bits 1 and 3 never go low, and the slot timing for digits 0 and 2 is unchanged.
5. Write on the exact boundary cycle with the buffer empty -> the payload is displayed starting one full frame later, not immediately.
6. Assert rst_n=0 during a digit2 SHOW with an update pending -> an=4'hF with no clock edge. After release, the display is dark (pending data dropped) and wr_ready=1.
